// File: rtl/loop_pkg.sv
// Shared definitions for the loop-replay front-end controller.
// States, the branch opcode and the instruction size in bytes.
package loop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_REPLAY,
        ST_FLUSH
    } loop_state_t;

    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/loop_buffer_mem.sv
// Loop body storage: DEPTH x XLEN register file, one synchronous write port
// and one registered read port. Contents are not reset.
module loop_buffer_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/loop_replay_ctrl.sv
// Detects short backward-branch loops, captures the body into a local buffer
// and replays it to decode with fetch stalled until the closing branch exits.
import loop_pkg::*;

module loop_replay_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [XLEN-1:0] fetch_instr,
    input  logic [XLEN-1:0] fetch_imm,
    input  logic            mispredict,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            block_fetch,
    output logic            flush,
    output logic [XLEN-1:0] new_pc
);

    localparam int unsigned AW = $clog2(DEPTH);

    loop_state_t     state_q, state_d;
    logic [XLEN-1:0] start_q, start_d, end_q, end_d, exp_q, exp_d;
    logic [AW-1:0]   len_m1_q, len_m1_d, rd_ptr_q, rd_ptr_d;
    logic            out_valid_q, out_valid_d, block_q, block_d, flush_q, flush_d;
    logic            src_buf_q, src_buf_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, out_instr_q, out_instr_d, new_pc_q, new_pc_d;

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] rdata, neg_imm, offs, span;
    logic            detect;

    loop_buffer_mem #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (fetch_instr),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        neg_imm = -fetch_imm;
        offs    = fetch_pc - start_q;
        span    = end_q - start_q;
        waddr   = offs[AW+1:2];
        // len = (-imm >> 2) + 1 <= DEPTH, written as (-imm >> 2) < DEPTH
        detect  = fetch_valid && (fetch_instr[6:0] == OPC_BRANCH) &&
                  fetch_imm[XLEN-1] && (fetch_imm[1:0] == 2'b00) &&
                  ((neg_imm >> 2) < XLEN'(DEPTH));

        state_d     = state_q;
        start_d     = start_q;
        end_d       = end_q;
        len_m1_d    = len_m1_q;
        exp_d       = exp_q;
        rd_ptr_d    = rd_ptr_q;
        we          = 1'b0;
        out_valid_d = fetch_valid;
        out_pc_d    = fetch_pc;
        out_instr_d = fetch_instr;
        block_d     = 1'b0;
        flush_d     = 1'b0;
        new_pc_d    = '0;
        src_buf_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (detect && !mispredict) begin
                    start_d  = fetch_pc + fetch_imm;
                    end_d    = fetch_pc;
                    len_m1_d = AW'(neg_imm >> 2);
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (mispredict) begin
                    state_d = ST_IDLE;
                end else if (fetch_valid) begin
                    if (fetch_pc == start_q) begin
                        we      = 1'b1;
                        exp_d   = start_q + XLEN'(INSTR_BYTES);
                        state_d = ST_CAPTURE;
                    end else if (offs > span) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (mispredict) begin
                    state_d = ST_IDLE;
                end else if (fetch_valid) begin
                    if (fetch_pc == exp_q) begin
                        we    = 1'b1;
                        exp_d = exp_q + XLEN'(INSTR_BYTES);
                        if (fetch_pc == end_q) begin
                            state_d  = ST_REPLAY;
                            block_d  = 1'b1;
                            rd_ptr_d = '0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REPLAY: begin
                // Read address runs one cycle ahead; out_instr comes straight off the read port
                if (mispredict) begin
                    state_d     = ST_FLUSH;
                    out_valid_d = 1'b0;
                    flush_d     = 1'b1;
                    new_pc_d    = end_q + XLEN'(INSTR_BYTES);
                end else begin
                    out_valid_d = 1'b1;
                    out_pc_d    = start_q + XLEN'(rd_ptr_q) * XLEN'(INSTR_BYTES);
                    out_instr_d = '0;
                    src_buf_d   = 1'b1;
                    block_d     = 1'b1;
                    rd_ptr_d    = (rd_ptr_q == len_m1_q) ? '0 : rd_ptr_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            start_q     <= '0;
            end_q       <= '0;
            len_m1_q    <= '0;
            exp_q       <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            block_q     <= 1'b0;
            flush_q     <= 1'b0;
            new_pc_q    <= '0;
            src_buf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            len_m1_q    <= len_m1_d;
            exp_q       <= exp_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            block_q     <= block_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            src_buf_q   <= src_buf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = src_buf_q ? rdata : out_instr_q;
    assign block_fetch = block_q;
    assign flush       = flush_q;
    assign new_pc      = new_pc_q;

endmodule

// File: tb/tb_loop_replay_ctrl.sv
// Randomized scoreboard bench for loop_replay_ctrl against a queue-based
// reference model of loop capture and replay.
module tb_loop_replay_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned XLEN  = 32;

    localparam int M_IDLE = 0, M_ARM = 1, M_CAP = 2, M_REP = 3, M_FLUSH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_valid, mispredict;
    logic [XLEN-1:0] fetch_pc, fetch_instr, fetch_imm;
    logic            out_valid, block_fetch, flush;
    logic [XLEN-1:0] out_pc, out_instr, new_pc;

    always #5 clk = ~clk;

    loop_replay_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_imm   (fetch_imm),
        .mispredict  (mispredict),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .block_fetch (block_fetch),
        .flush       (flush),
        .new_pc      (new_pc)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        blk;
        logic        fl;
        logic [31:0] npc;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    bit   mon_en = 1'b0;

    // reference model state
    int          mode;
    logic [31:0] lstart, lend;
    int          llen, rep_i;
    logic [31:0] body[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL scoreboard_empty: got output cycle expected none at %0t", $time);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(e.v));
                chk("block_fetch", 32'(block_fetch), 32'(e.blk));
                chk("flush", 32'(flush), 32'(e.fl));
                if (e.v) begin
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.ins);
                end
                if (e.fl) chk("new_pc", new_pc, e.npc);
            end
        end
    end

    function automatic bit is_loop(logic fv, logic [31:0] ins, logic [31:0] imm);
        logic [6:0] opc;
        longint     simm;
        opc  = ins[6:0];
        simm = longint'($signed(imm));
        if (!fv || opc != 7'b1100011) return 1'b0;
        if (simm >= 0 || (simm % 4) != 0) return 1'b0;
        return ((-simm) / 4 + 1) <= longint'(DEPTH);
    endfunction

    task automatic model_step(logic fv, logic [31:0] pc, logic [31:0] ins,
                              logic [31:0] imm, logic mp);
        rec_t r;
        r = '{v: fv, pc: pc, ins: ins, blk: 1'b0, fl: 1'b0, npc: 32'h0};
        case (mode)
            M_IDLE: if (!mp && is_loop(fv, ins, imm)) begin
                lstart = pc + imm;
                lend   = pc;
                llen   = int'((-longint'($signed(imm))) / 4) + 1;
                mode   = M_ARM;
            end
            M_ARM: if (mp) mode = M_IDLE;
                   else if (fv) begin
                       if (pc == lstart) begin
                           body.delete();
                           body.push_back(ins);
                           mode = M_CAP;
                       end else if ((pc - lstart) > (lend - lstart)) mode = M_IDLE;
                   end
            M_CAP: if (mp) mode = M_IDLE;
                   else if (fv) begin
                       if (pc == lstart + 32'(4 * body.size())) begin
                           body.push_back(ins);
                           if (pc == lend) begin
                               mode  = M_REP;
                               rep_i = 0;
                               r.blk = 1'b1;
                           end
                       end else mode = M_IDLE;
                   end
            M_REP: if (mp) begin
                       r = '{v: 1'b0, pc: 32'h0, ins: 32'h0, blk: 1'b0, fl: 1'b1, npc: lend + 32'd4};
                       mode = M_FLUSH;
                   end else begin
                       r.v   = 1'b1;
                       r.pc  = lstart + 32'(4 * rep_i);
                       r.ins = body[rep_i];
                       r.blk = 1'b1;
                       rep_i = (rep_i + 1) % llen;
                   end
            default: begin
                r.v  = 1'b0;
                mode = M_IDLE;
            end
        endcase
        exp_q.push_back(r);
    endtask

    task automatic cyc(logic fv, logic [31:0] pc, logic [31:0] ins,
                       logic [31:0] imm, logic mp);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = ins;
        fetch_imm   = imm;
        mispredict  = mp;
        model_step(fv, pc, ins, imm, mp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_br();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], 7'b1100011};
    endfunction

    function automatic logic [31:0] mk_op();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], 7'b0010011};
    endfunction

    task automatic start_clean();
        mode = M_IDLE;
        exp_q.delete();
        exp_q.push_back('{v: 1'b0, pc: 32'h0, ins: 32'h0, blk: 1'b0, fl: 1'b0, npc: 32'h0});
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_block_fetch", 32'(block_fetch), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        fetch_valid = 1'b1;
        mispredict  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_flush", 32'(flush), 32'h0);
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        reset = 1'b1;
        fetch_valid = 1'b0;
        mispredict  = 1'b0;
        start_clean();
    endtask

    // Detect, capture and replay the 4-instruction loop at 0x100..0x10C
    task automatic enter_demo_loop(logic [31:0] br);
        cyc(1, 32'h10C, br, -32'sd12, 0);
        cyc(1, 32'h100, 32'h13, 0, 0);
        cyc(1, 32'h104, 32'h14, 0, 0);
        cyc(1, 32'h108, 32'h15, 0, 0);
        cyc(1, 32'h10C, br, -32'sd12, 0);
    endtask

    task automatic rand_scenario();
        int          len, pre;
        logic [31:0] s, imm, br, pc;
        bit          corrupt;
        len = $urandom_range(2, DEPTH + 3);
        s   = $urandom;
        s[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) s = 32'hFFFF_FFF0;
        imm = 32'(-(4 * (len - 1)));
        br  = mk_br();
        pre = $urandom_range(0, 3);
        for (int i = 0; i < pre; i++)
            cyc(1'($urandom_range(0, 1)), $urandom, mk_op(), $urandom, 1'($urandom_range(0, 1)));
        cyc(1, s + imm, br, imm, ($urandom_range(0, 7) == 0));
        corrupt = ($urandom_range(0, 5) == 0);
        for (int k = 0; k < len; k++) begin
            while ($urandom_range(0, 3) == 0) cyc(0, $urandom, mk_op(), 0, 0);
            pc = s + 32'(4 * k);
            if (corrupt && k == len / 2) pc = pc + 32'd8;
            cyc(1, pc, (k == len - 1) ? br : mk_op(), (k == len - 1) ? imm : 32'h0,
                ($urandom_range(0, 29) == 0));
        end
        if (mode == M_REP) begin
            int n;
            n = $urandom_range(0, 2 * len + 2);
            for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), $urandom, mk_op(), $urandom, 0);
            if ($urandom_range(0, 9) == 0) begin
                do_reset();
            end else begin
                cyc(1, $urandom, mk_op(), 0, 1);
                cyc(0, 0, 0, 0, 0);
                cyc(1, s + imm + 32'd4, mk_op(), 0, 0);
            end
        end
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] br;
        reset       = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        fetch_instr = '0;
        fetch_imm   = '0;
        mispredict  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_out_valid", 32'(out_valid), 32'h0);
        chk("init_block_fetch", 32'(block_fetch), 32'h0);
        reset = 1'b1;
        start_clean();

        // pass-through
        cyc(1, 32'h100, 32'h13, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // capture, replay >= 3 iterations, exit via mispredict
        br = 32'h FE00_0EE3;
        enter_demo_loop(br);
        repeat (14) cyc(1'($urandom_range(0, 1)), $urandom, mk_op(), $urandom, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h110, 32'h16, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // rejects: too long, positive offset, capture diverges
        cyc(1, 32'h180, br, -32'sd128, 0);
        cyc(1, 32'h100, 32'h13, 0, 0);
        cyc(1, 32'h104, 32'h14, 0, 0);
        cyc(1, 32'h10C, br, 32'sd12, 0);
        cyc(1, 32'h118, 32'h13, 0, 0);
        cyc(1, 32'h10C, br, -32'sd12, 0);
        cyc(1, 32'h100, 32'h13, 0, 0);
        cyc(1, 32'h104, 32'h14, 0, 0);
        cyc(1, 32'h200, 32'h15, 0, 0);
        cyc(1, 32'h204, 32'h16, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // mispredict together with detect
        cyc(1, 32'h10C, br, -32'sd12, 1);
        cyc(1, 32'h100, 32'h13, 0, 0);
        cyc(1, 32'h104, 32'h14, 0, 0);
        cyc(1, 32'h108, 32'h15, 0, 0);
        cyc(1, 32'h10C, 32'h17, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // reset during replay
        enter_demo_loop(br);
        repeat (3) cyc(0, 0, 0, 0, 0);
        do_reset();
        cyc(1, 32'h100, 32'h13, 0, 0);
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) rand_scenario();

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/loop_replay_ctrl.md
# loop_replay_ctrl

Fetch-side controller that detects short backward-branch loops, captures the loop body into a local buffer and replays it to decode while fetch is stalled. It sits between instruction fetch and decode. It drives `block_fetch` to idle the I-side and `flush`/`new_pc` to redirect the front end when execute reports the loop-closing branch mispredicted (loop exit).

## Interface
- `DEPTH`, 16, loop buffer entries (power of 2, ≥4); max loop body length in instructions, branch included.
- `XLEN`, 32, PC/instruction/immediate width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch word valid this cycle.
- `fetch_pc`  in  XLEN  PC of fetch word.
- `fetch_instr`  in  XLEN  fetched instruction.
- `fetch_imm`  in  XLEN  sign-extended B-type byte offset of `fetch_instr`.
- `mispredict`  in  1  execute: loop-closing branch resolved not-taken.
- `out_valid`  out  1  instruction to decode valid.
- `out_pc`  out  XLEN  PC to decode.
- `out_instr`  out  XLEN  instruction to decode.
- `block_fetch`  out  1  stall fetch; fetch inputs ignored while high.
- `flush`  out  1  one-cycle front-end flush.
- `new_pc`  out  XLEN  redirect target, meaningful while `flush`=1.

## Operation
- States: IDLE, ARM, CAPTURE, REPLAY, FLUSH.
- Loop detect: `fetch_valid` && `fetch_instr[6:0]`==7'b1100011 && `fetch_imm[XLEN-1]`==1 && `fetch_imm[1:0]`==0 && len=((-imm)>>2)+1 ≤ DEPTH.
- On detect, latch loop_end=`fetch_pc`, loop_start=`fetch_pc`+imm, len.
- IDLE: pass-through. On detect, go to ARM.
- ARM: pass-through.
  - Valid fetch with pc==loop_start: write entry 0, expected=start+4, go to CAPTURE.
  - Valid fetch outside [start,end]: go to IDLE.
- CAPTURE: pass-through. Each valid fetch must have pc==expected.
  - On match: write entry (pc−start)>>2 and increment expected.
  - On mismatch: go to IDLE. No replay; buffer contents are discarded.
  - When pc==loop_end is written: go to REPLAY.
- REPLAY: `block_fetch`=1 and `out_valid`=1 every cycle.
  - rd_ptr runs 0..len−1 and wraps to 0.
  - `out_pc`=start+4·rd_ptr; `out_instr`=buffer[rd_ptr].
- `mispredict` handling:
  - In REPLAY: go to FLUSH.
  - In ARM/CAPTURE: go to IDLE without flush.
  - In IDLE/FLUSH: ignored.
- FLUSH: one cycle. `flush`=1, `new_pc`=loop_end+4, `out_valid`=0, `block_fetch`=0. Then go to IDLE.
- Simultaneous events: `mispredict` beats detect/capture in the same cycle.
- PC arithmetic is modulo 2^XLEN.

## Timing
- Reset: state IDLE and all outputs 0, immediately on `reset` low (asynchronous).
- Pass-through latency 1 cycle. A fetch word at cycle N appears on out_* at N+1; `out_valid` at N+1 equals `fetch_valid` at N.
- Cycle C presents loop_end in CAPTURE:
  - C+1: REPLAY, `block_fetch`=1, out shows loop_end (pass-through). Fetch word at C+1 is dropped.
  - C+2: out shows entry 0 (loop_start).
  - Result: the out stream has no bubble.
- `mispredict` at cycle M in REPLAY (including C+1): out_* at M still valid.
  - M+1: FLUSH.
  - M+2: IDLE, `block_fetch`=0, pass-through resumes.
- `block_fetch` and `flush` are registered outputs. `flush` is high exactly one cycle.

## Structure
- Shared package `loop_pkg`:
  - state enum.
  - `OPC_BRANCH`=7'b1100011.
  - `INSTR_BYTES`=4.
- Sub-module `loop_buffer_mem`: DEPTH×XLEN register file with one synchronous write port and one read port.
  - Read port is registered; the controller issues the read address one cycle ahead.
  - No reset on contents.
- The controller holds the FSM, loop_start/end/len registers, expected-PC and rd_ptr counters, and the output mux.

## Test plan
- Reset: assert `reset`=0 mid-stream → all outputs 0 at once. Release → IDLE pass-through.
- Pass-through: pc 0x100, instr 0x00000013, valid → next cycle `out_pc`=0x100, `out_instr`=0x13, `block_fetch`=0.
- Capture/replay: IDLE, branch at 0x10C, imm=−12 (opcode 1100011) → ARM. Then 0x100/0x13, 0x104/0x14, 0x108/0x15, 0x10C/branch → `block_fetch`=1; out repeats 0x100,0x104,0x108,0x10C with matching instructions for ≥3 iterations, no gap.
- Exit: `mispredict` during replay → one cycle `flush`=1, `new_pc`=0x110, then `block_fetch`=0. Fetch 0x110/0x16 passes through.
- Rejects:
  - Branch imm=−128 with DEPTH=16 → no ARM.
  - Positive imm → no ARM.
  - Capture sees 0x104 then 0x200 → IDLE, `block_fetch` never 1.
- Simultaneous/reset:
  - `mispredict` in the same cycle as detect → stays IDLE.
  - `reset` low during REPLAY → outputs 0, `flush` not asserted.
